// File: rtl/sample_tick_scheduler.sv
// Frame sequencer: emits N_SAMPLES registered strobes with period div_cfg+1, then holds frame_done
// until ack. Optional macro SCHED_AUTORUN_EN adds an autorun input that chains frames on ack.
module sample_tick_scheduler #(
   parameter int unsigned N_SAMPLES = 8,
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned IDX_W     = $clog2(N_SAMPLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] div_cfg,
   input  logic             ack,
`ifdef SCHED_AUTORUN_EN
   input  logic             autorun,
`endif
   output logic             sample_en,
   output logic [IDX_W-1:0] sample_idx,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [IDX_W-1:0] nxt_q, nxt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             en_q, en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tick;
   logic             last;
   logic             rerun;

`ifdef SCHED_AUTORUN_EN
   assign rerun = autorun;
`else
   assign rerun = 1'b0;
`endif

   assign tick = (cnt_q == div_q);
   // nxt_q is the index the next strobe will carry
   assign last = (nxt_q == IDX_W'(N_SAMPLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StRun;
         end
         StRun: begin
            if (abort)             state_d = StIdle;
            else if (tick && last) state_d = StDone;
         end
         StDone: begin
            if (abort)    state_d = StIdle;
            else if (ack) state_d = rerun ? StRun : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      nxt_d  = nxt_q;
      idx_d  = idx_q;
      en_d   = 1'b0;
      busy_d = busy_q;
      done_d = done_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               div_d  = div_cfg;
               cnt_d  = '0;
               nxt_d  = '0;
               idx_d  = '0;
               busy_d = 1'b1;
            end
         end
         StRun: begin
            if (abort) begin
               cnt_d  = '0;
               busy_d = 1'b0;
               done_d = 1'b0;
            end else if (tick) begin
               cnt_d = '0;
               en_d  = 1'b1;
               idx_d = nxt_q;
               nxt_d = last ? '0 : nxt_q + 1'b1;
               if (last) done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (abort) begin
               cnt_d  = '0;
               busy_d = 1'b0;
               done_d = 1'b0;
            end else if (ack) begin
               done_d = 1'b0;
               if (rerun) begin
                  div_d = div_cfg;
                  cnt_d = '0;
                  nxt_d = '0;
                  idx_d = '0;
               end else begin
                  busy_d = 1'b0;
               end
            end
         end
         default: begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         div_q  <= '0;
         nxt_q  <= '0;
         idx_q  <= '0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         nxt_q  <= nxt_d;
         idx_q  <= idx_d;
         en_q   <= en_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign sample_en  = en_q;
   assign sample_idx = idx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_sample_tick_scheduler.sv
// Self-checking bench for sample_tick_scheduler: vector table, directed corner sequences and
// randomized traffic against a timing-arithmetic reference model.
module tb_sample_tick_scheduler;

   localparam int N  = 8;
   localparam int DW = 16;
   localparam int IW = 3;

   logic          clk;
   logic          reset;
   logic          start;
   logic          abort;
   logic [DW-1:0] div_cfg;
   logic          ack;
`ifdef SCHED_AUTORUN_EN
   logic          autorun;
`endif
   logic          sample_en;
   logic [IW-1:0] sample_idx;
   logic          busy;
   logic          frame_done;

   sample_tick_scheduler #(
      .N_SAMPLES (N),
      .DIV_W     (DW),
      .IDX_W     (IW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .div_cfg    (div_cfg),
      .ack        (ack),
`ifdef SCHED_AUTORUN_EN
      .autorun    (autorun),
`endif
      .sample_en  (sample_en),
      .sample_idx (sample_idx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_strb = 0;

   // Reference: mode 0 idle, 1 run, 2 done; strobe timing from elapsed edges since frame start
   int     m_mode;
   longint m_t;
   longint m_d;
   int     m_idx;
   logic   m_en, m_busy, m_done;

   typedef struct {
      logic          st;
      logic          ab;
      logic          ak;
      logic [DW-1:0] dc;
      logic          en;
      logic [IW-1:0] idx;
      logic          bz;
      logic          fd;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic cur_ar();
`ifdef SCHED_AUTORUN_EN
      return autorun;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_mode = 0; m_t = 0; m_d = 0; m_idx = 0;
      m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_edge(input logic s, input logic a, input logic k, input logic ar,
                             input logic [DW-1:0] dc);
      case (m_mode)
         0: begin
            m_en = 1'b0;
            if (s) begin
               m_mode = 1; m_t = 0; m_d = longint'(dc); m_idx = 0; m_busy = 1'b1;
            end
         end
         1: begin
            if (a) begin
               m_mode = 0; m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            end else begin
               m_t++;
               if (m_t % (m_d + 1) == 0) begin
                  m_en  = 1'b1;
                  m_idx = int'(m_t / (m_d + 1)) - 1;
                  if (m_idx == N - 1) begin
                     m_mode = 2; m_done = 1'b1;
                  end
               end else begin
                  m_en = 1'b0;
               end
            end
         end
         default: begin
            m_en = 1'b0;
            if (a) begin
               m_mode = 0; m_busy = 1'b0; m_done = 1'b0;
            end else if (k) begin
               m_done = 1'b0;
               if (ar) begin
                  m_mode = 1; m_t = 0; m_d = longint'(dc); m_idx = 0;
               end else begin
                  m_mode = 0; m_busy = 1'b0;
               end
            end
         end
      endcase
   endtask

   task automatic check_model(input string tag);
      check({tag, ".en"},   int'(sample_en),  int'(m_en));
      check({tag, ".idx"},  int'(sample_idx), m_idx);
      check({tag, ".busy"}, int'(busy),       int'(m_busy));
      check({tag, ".done"}, int'(frame_done), int'(m_done));
   endtask

   task automatic cyc(input logic s, input logic a, input logic k, input logic [DW-1:0] dc);
      @(negedge clk);
      start = s; abort = a; ack = k; div_cfg = dc;
      @(posedge clk);
      model_edge(s, a, k, cur_ar(), dc);
      #1;
      if (sample_en) n_strb++;
      check_model("model");
   endtask

   task automatic idle_n(input int n, input logic [DW-1:0] dc);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, dc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset.en",   int'(sample_en),  0);
      check("reset.idx",  int'(sample_idx), 0);
      check("reset.busy", int'(busy),       0);
      check("reset.done", int'(frame_done), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; div_cfg = '0;
`ifdef SCHED_AUTORUN_EN
      autorun = 1'b0;
`endif
      model_reset();

      tbl[0] = '{st: 1'b1, ab: 1'b0, ak: 1'b0, dc: 16'd0, en: 1'b0, idx: 3'd0, bz: 1'b1, fd: 1'b0};
      for (int k = 0; k < N; k++)
         tbl[1+k] = '{st: 1'b0, ab: 1'b0, ak: 1'b0, dc: 16'd0, en: 1'b1, idx: IW'(k), bz: 1'b1,
                      fd: (k == N - 1)};
      tbl[9]  = '{st: 1'b0, ab: 1'b0, ak: 1'b0, dc: 16'd0, en: 1'b0, idx: 3'd7, bz: 1'b1, fd: 1'b1};
      tbl[10] = '{st: 1'b0, ab: 1'b0, ak: 1'b1, dc: 16'd0, en: 1'b0, idx: 3'd7, bz: 1'b0, fd: 1'b0};
      tbl[11] = '{st: 1'b0, ab: 1'b1, ak: 1'b1, dc: 16'd0, en: 1'b0, idx: 3'd7, bz: 1'b0, fd: 1'b0};

      do_reset();

      // div_cfg=0 frame: strobe every cycle
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].st, tbl[i].ab, tbl[i].ak, tbl[i].dc);
         check($sformatf("tbl%0d.en", i),   int'(sample_en),  int'(tbl[i].en));
         check($sformatf("tbl%0d.idx", i),  int'(sample_idx), int'(tbl[i].idx));
         check($sformatf("tbl%0d.busy", i), int'(busy),       int'(tbl[i].bz));
         check($sformatf("tbl%0d.done", i), int'(frame_done), int'(tbl[i].fd));
      end

      // Nominal frame div=3: strobes at edges 4,8,..,32 after start
      cyc(1'b1, 1'b0, 1'b0, 16'd3);
      for (int i = 1; i <= 32; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 16'd3);
         check($sformatf("nom.strobe%0d", i), int'(sample_en), int'(i % 4 == 0));
         if (i % 4 == 0) check($sformatf("nom.idx%0d", i), int'(sample_idx), i / 4 - 1);
      end
      check("nom.done_rise", int'(frame_done), 1);
      idle_n(10, 16'd3);
      check("nom.done_hold", int'(frame_done), 1);
      check("nom.busy_hold", int'(busy), 1);
      cyc(1'b0, 1'b0, 1'b1, 16'd3);
      check("nom.busy_ack", int'(busy), 0);

      // Async reset mid-RUN
      cyc(1'b1, 1'b0, 1'b0, 16'd3);
      idle_n(9, 16'd3);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("areset.en",   int'(sample_en),  0);
      check("areset.idx",  int'(sample_idx), 0);
      check("areset.busy", int'(busy),       0);
      check("areset.done", int'(frame_done), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_strb = 0;
      idle_n(20, 16'd3);
      check("areset.no_strobes", n_strb, 0);

      // Abort on 3rd strobe, div=2
      cyc(1'b1, 1'b0, 1'b0, 16'd2);
      idle_n(9, 16'd2);
      check("abort.third_en",  int'(sample_en),  1);
      check("abort.third_idx", int'(sample_idx), 2);
      cyc(1'b0, 1'b1, 1'b0, 16'd2);
      check("abort.busy", int'(busy), 0);
      n_strb = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 16'd2);
         if (frame_done) check("abort.done_seen", 1, 0);
      end
      check("abort.no_strobes", n_strb, 0);

      // Config and start while busy are ignored
      cyc(1'b1, 1'b0, 1'b0, 16'd3);
      idle_n(10, 16'd3);
      cyc(1'b1, 1'b0, 1'b0, 16'd9);
      idle_n(21, 16'd9);
      check("cfg.done_on_time", int'(frame_done), 1);
      cyc(1'b0, 1'b0, 1'b1, 16'd9);
      idle_n(3, 16'd9);
      check("cfg.no_second_frame", int'(busy), 0);
      cyc(1'b1, 1'b0, 1'b0, 16'd9);
      idle_n(9, 16'd9);
      check("cfg.new_pre", int'(sample_en), 0);
      cyc(1'b0, 1'b0, 1'b0, 16'd9);
      check("cfg.new_first", int'(sample_en), 1);
      cyc(1'b0, 1'b1, 1'b0, 16'd9);

      // start+ack together in DONE
      cyc(1'b1, 1'b0, 1'b0, 16'd0);
      idle_n(9, 16'd0);
      cyc(1'b1, 1'b0, 1'b1, 16'd0);
      check("stack.busy", int'(busy), 0);
      n_strb = 0;
      idle_n(12, 16'd0);
      check("stack.no_strobes", n_strb, 0);

`ifdef SCHED_AUTORUN_EN
      cyc(1'b1, 1'b0, 1'b0, 16'd1);
      idle_n(17, 16'd1);
      autorun = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 16'd4);
      autorun = 1'b0;
      check("auto.busy", int'(busy), 1);
      check("auto.done", int'(frame_done), 0);
      idle_n(4, 16'd4);
      check("auto.pre", int'(sample_en), 0);
      cyc(1'b0, 1'b0, 1'b0, 16'd4);
      check("auto.first", int'(sample_en), 1);
      cyc(1'b0, 1'b1, 1'b0, 16'd4);
`endif

      // Maximum divisor: first strobe after 2^16 edges
      cyc(1'b1, 1'b0, 1'b0, 16'hFFFF);
      n_strb = 0;
      idle_n(65535, 16'hFFFF);
      check("maxdiv.pre", n_strb, 0);
      cyc(1'b0, 1'b0, 1'b0, 16'hFFFF);
      check("maxdiv.first", int'(sample_en), 1);
      cyc(1'b0, 1'b1, 1'b0, 16'hFFFF);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
`ifdef SCHED_AUTORUN_EN
         autorun = ($urandom_range(0, 1) == 1);
`endif
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 5) == 0), DW'($urandom_range(0, 4)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sample_tick_scheduler.md
Name: sample_tick_scheduler

Overview:
- Frame sequencer for the Fourier-transform capture path.
- Produces programmable-rate single-cycle sample strobes using the same divider semantics as the existing clock divider: a period of DIV+1 clocks.
- Counts N_SAMPLES strobes per frame, drives the sample index, then raises frame_done and holds it until the downstream transform acknowledges.
- Sits between control logic (start/abort/config) and the sample register/DFT accumulators.

Parameters:
- N_SAMPLES, 8: strobes per frame; legal range is 2 or more.
- DIV_W, 16: width of the divisor config.
- IDX_W, $clog2(N_SAMPLES): width of sample_idx.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a frame; sampled only in IDLE.
- abort  input  1  cancel the frame in RUN or DONE.
- div_cfg  input  DIV_W  divisor; strobe period is div_cfg+1 clocks; latched at start acceptance.
- ack  input  1  downstream has consumed the frame; sampled only in DONE.
- sample_en  output  1  registered single-cycle sample strobe.
- sample_idx  output  IDX_W  index of the current or last strobe, 0..N_SAMPLES-1.
- busy  output  1  high in RUN and DONE.
- frame_done  output  1  high throughout DONE.

Behaviour:
- Reset (async, any time): state=IDLE, cnt=0, div_q=0, sample_en=0, sample_idx=0, busy=0, frame_done=0. Reset during RUN or DONE discards the frame, with no further strobes.
- States: IDLE, RUN, DONE; all outputs are registered.
- IDLE:
  - start=1 at edge E0 goes to RUN.
  - On that edge: div_q<=div_cfg, cnt<=0, sample_idx<=0, busy<=1.
  - abort and ack are ignored.
- RUN, each edge:
  - If cnt==div_q: cnt<=0 and sample_en<=1. Otherwise cnt<=cnt+1 and sample_en<=0.
  - Strobe k (k=0..N_SAMPLES-1) is high in the cycle after edge E0+(k+1)(div_q+1).
  - div_q=0 gives a strobe every cycle.
  - sample_idx<=k on the edge that raises strobe k; it holds between strobes.
  - The edge that raises strobe N_SAMPLES-1 also moves to DONE and sets frame_done<=1. That strobe is still emitted in full.
- DONE:
  - sample_en is 0 after the first DONE cycle.
  - frame_done=1 and busy=1 persist until ack=1.
  - On the ack edge: IDLE, frame_done<=0, busy<=0, sample_idx holds its last value.
- abort=1 in RUN or DONE: next edge goes to IDLE, sample_en<=0, frame_done<=0, busy<=0, cnt<=0. No frame_done pulse is generated by an aborted RUN.
- Priority (highest first): reset, abort, ack/strobe logic, start.
- start while busy is ignored; it is not queued.
- start and ack together in DONE: ack wins and the state returns to IDLE. A new frame needs start in a later IDLE cycle.
- div_cfg changes while busy have no effect until the next start acceptance.
- The cnt comparison is unsigned, full DIV_W width. div_cfg=2^DIV_W-1 gives a period of 2^DIV_W clocks with no overflow.

Optional Feature:
- SCHED_AUTORUN_EN defined:
  - Extra input autorun (1 bit).
  - In DONE with autorun=1, ack goes directly to RUN, not IDLE.
  - On that edge: re-latch div_cfg, cnt<=0, sample_idx<=0, frame_done<=0, busy stays 1.
  - The first strobe of the new frame follows the same E0+(div_q+1) timing, measured from the ack edge.
  - abort still returns to IDLE.
- Undefined: no autorun port, and DONE+ack always goes to IDLE.

Test Plan:
- Reset mid-RUN: assert reset during a frame, with div_cfg=3 and N=8 -> all outputs 0 immediately (async); no sample_en for 20 cycles after release without start.
- Nominal frame: div_cfg=3, N=8, start one cycle -> 8 strobes spaced 4 clocks, first 4 clocks after start edge; sample_idx 0..7; frame_done rises with strobe 7's edge; hold ack low 10 cycles -> frame_done stays 1; ack -> busy=0 next cycle.
- div_cfg=0 -> strobes on 8 consecutive cycles, sample_idx 0..7 one per cycle, frame_done on the 8th.
- Abort at 3rd strobe (div_cfg=2) -> IDLE next edge; no further strobes, frame_done never 1, busy=0.
- Config/start while busy: change div_cfg from 3 to 9 and pulse start mid-frame -> spacing stays 4, no second frame. Next start uses spacing 10.
- Simultaneous start+ack in DONE -> IDLE, no strobe for 12 cycles. With SCHED_AUTORUN_EN and autorun=1: ack -> new frame, first strobe div_cfg+1 clocks after the ack edge.
